ts_conv_ctrl: RTL and testbench

- Conversion sequencer for the temperature-sensor analog macro.
- Powers the sensor up, waits for it to settle, issues start pulses and collects each conversion on DETOK (with a timeout).
- Averages 2^AVG_LOG2 samples, applies a signed trim offset, and publishes a saturated 8-bit result with a valid strobe.
- Sits in TS_top between the register block / clock-lock logic and the A2D/D2A analog boundary, on the 16 MHz oscillator clock.

---
 rtl/ts_conv_ctrl.sv | 152 +++++++++++++++
 tb/tb_ts_conv_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_conv_ctrl.sv
// Temperature-sensor conversion sequencer: powers the sensor up, settles, runs the
// START/DETOK handshake, averages samples, applies signed trim, publishes a saturated code.
module ts_conv_ctrl #(
  parameter int SETTLE_CYC  = 16,
  parameter int START_CYC   = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int PERIOD_CYC  = 4096,
  parameter int AVG_LOG2    = 2
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       FLOCK,
  input  logic       reg_ts_en_sel,
  input  logic       sw_trig,
  input  logic [3:0] reg_offset,
  input  logic       A2D_TS_DETOK,
  input  logic [7:0] A2D_TS_DOUT,
  output logic       D2A_TS_EN,
  output logic       D2A_TS_START_EN,
  output logic [7:0] ts_out,
  output logic       ts_valid,
  output logic       ts_err,
  output logic       ts_busy
);

  localparam int ACC_W   = 8 + AVG_LOG2;
  localparam int CNT_W   = AVG_LOG2 + 1;
  localparam int NSAMP   = 1 << AVG_LOG2;
  localparam int MAX_SS  = (SETTLE_CYC > START_CYC) ? SETTLE_CYC : START_CYC;
  localparam int TMR_MAX = (TIMEOUT_CYC > MAX_SS) ? TIMEOUT_CYC : MAX_SS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int PER_W   = $clog2(PERIOD_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PWRUP, S_START, S_WAIT_OK, S_ACC, S_DONE
  } state_t;

  state_t             state, next_state;
  logic [TMR_W-1:0]   tmr;
  logic [PER_W-1:0]   per_cnt;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               armed;
  logic               detok_m, detok_s;
  logic               round_start, capture, timeout, publish;
  logic [7:0]         avg;
  logic signed [9:0]  trimmed;
  logic [7:0]         result;

  // DETOK comes straight from the analog macro; two flops before any decision uses it.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      detok_m <= 1'b0;
      detok_s <= 1'b0;
    end else begin
      detok_m <= A2D_TS_DETOK;
      detok_s <= detok_m;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    next_state  = state;
    round_start = 1'b0;
    capture     = 1'b0;
    timeout     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (FLOCK && ((reg_ts_en_sel && per_cnt == '0) || (!reg_ts_en_sel && sw_trig))) begin
          next_state  = S_PWRUP;
          round_start = 1'b1;
        end
      end
      S_PWRUP:   if (tmr == TMR_W'(SETTLE_CYC - 1)) next_state = S_START;
      S_START:   if (tmr == TMR_W'(START_CYC - 1))  next_state = S_WAIT_OK;
      S_WAIT_OK: begin
        if (armed && detok_s) begin
          capture    = 1'b1;
          next_state = S_ACC;
        end else if (tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
          timeout    = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_ACC:     next_state = (cnt < CNT_W'(NSAMP)) ? S_START : S_DONE;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
    // Losing clock lock aborts silently from any active state.
    if (state != S_IDLE && !FLOCK) begin
      next_state = S_IDLE;
      capture    = 1'b0;
      timeout    = 1'b0;
    end
  end

  assign publish = (state == S_DONE) && FLOCK;

  always_comb begin
    avg     = acc[AVG_LOG2 +: 8];
    trimmed = $signed({2'b00, avg}) + $signed({{6{reg_offset[3]}}, reg_offset});
    if (trimmed[9])                result = 8'd0;
    else if (trimmed > 10'sd255)   result = 8'hFF;
    else                           result = trimmed[7:0];
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state           <= S_IDLE;
      tmr             <= '0;
      per_cnt         <= '0;
      acc             <= '0;
      cnt             <= '0;
      armed           <= 1'b0;
      D2A_TS_EN       <= 1'b0;
      D2A_TS_START_EN <= 1'b0;
      ts_out          <= 8'd0;
      ts_valid        <= 1'b0;
      ts_err          <= 1'b0;
    end else begin
      state <= next_state;

      if (next_state != state)  tmr <= '0;
      else if (state != S_IDLE) tmr <= tmr + 1'b1;

      if (round_start)                                    per_cnt <= PER_W'(PERIOD_CYC - 1);
      else if (FLOCK && reg_ts_en_sel && per_cnt != '0)   per_cnt <= per_cnt - 1'b1;

      // A capture needs DETOK to have been seen low since this START began.
      if (next_state == S_START && state != S_START)                  armed <= 1'b0;
      else if ((state == S_START || state == S_WAIT_OK) && !detok_s)  armed <= 1'b1;

      if (capture) begin
        acc <= acc + ACC_W'(A2D_TS_DOUT);
        cnt <= cnt + 1'b1;
      end else if (next_state == S_IDLE) begin
        acc <= '0;
        cnt <= '0;
      end

      D2A_TS_EN       <= (next_state != S_IDLE);
      D2A_TS_START_EN <= (next_state == S_START);
      ts_valid        <= publish;
      ts_err          <= timeout;
      if (publish) ts_out <= result;
    end
  end

  assign ts_busy = (state != S_IDLE);

endmodule

// File: tb/tb_ts_conv_ctrl.sv
// Self-checking bench for ts_conv_ctrl: table-driven single-shot rounds plus directed
// sequences for timeout, stuck DETOK, FLOCK loss, continuous mode and async reset.
module tb_ts_conv_ctrl;

  localparam int START_CYC   = 8;
  localparam int TIMEOUT_CYC = 1024;
  localparam int PERIOD_CYC  = 4096;

  logic       clk = 1'b0;
  logic       RSTn, FLOCK, reg_ts_en_sel, sw_trig;
  logic [3:0] reg_offset;
  logic       A2D_TS_DETOK;
  logic [7:0] A2D_TS_DOUT;
  logic       D2A_TS_EN, D2A_TS_START_EN, ts_valid, ts_err, ts_busy;
  logic [7:0] ts_out;

  ts_conv_ctrl dut (
    .clk(clk), .RSTn(RSTn), .FLOCK(FLOCK), .reg_ts_en_sel(reg_ts_en_sel),
    .sw_trig(sw_trig), .reg_offset(reg_offset), .A2D_TS_DETOK(A2D_TS_DETOK),
    .A2D_TS_DOUT(A2D_TS_DOUT), .D2A_TS_EN(D2A_TS_EN), .D2A_TS_START_EN(D2A_TS_START_EN),
    .ts_out(ts_out), .ts_valid(ts_valid), .ts_err(ts_err), .ts_busy(ts_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Output monitor, sampled on the falling edge.
  int   cyc = 0, start_pulses = 0, bad_width = 0, start_run = 0;
  int   valid_cnt = 0, err_cnt = 0, en_rises = 0, wait_entry_t = 0, err_t = 0;
  int   en_rise_t[$];
  logic start_prev = 1'b0, en_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (D2A_TS_START_EN) start_run++;
    else if (start_prev) begin
      start_pulses++;
      if (start_run != START_CYC) bad_width++;
      start_run    = 0;
      wait_entry_t = cyc;
    end
    if (D2A_TS_EN && !en_prev) begin
      en_rises++;
      en_rise_t.push_back(cyc);
    end
    if (ts_valid) valid_cnt++;
    if (ts_err) begin
      err_cnt++;
      err_t = cyc;
    end
    start_prev = D2A_TS_START_EN;
    en_prev    = D2A_TS_EN;
  end

  // Sensor model: DETOK drops after START rises, returns conv_dly cycles later with data.
  typedef enum {SENS_NORMAL, SENS_STUCK0, SENS_STUCK1} sens_mode_t;
  sens_mode_t sens_mode   = SENS_NORMAL;
  int         conv_dly    = 30;
  int         stuck_after = 0;
  int         sens_starts = 0;
  logic [7:0] samp_q[$];

  initial begin
    A2D_TS_DETOK = 1'b0;
    A2D_TS_DOUT  = 8'd0;
    forever begin
      @(posedge D2A_TS_START_EN);
      #1;
      sens_starts++;
      if (sens_mode == SENS_STUCK1) continue;
      A2D_TS_DETOK = 1'b0;
      if (sens_mode == SENS_STUCK0 && sens_starts > stuck_after) continue;
      repeat (conv_dly - 1) @(posedge clk);
      #1;
      if (samp_q.size() > 0) A2D_TS_DOUT = samp_q.pop_front();
      else                   A2D_TS_DOUT = 8'd0;
      A2D_TS_DETOK = 1'b1;
    end
  end

  typedef struct {
    logic [3:0][7:0] s;
    logic [3:0]      off;
    logic [7:0]      exp;
    int              dly;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, input logic [3:0] off,
                              input logic [7:0] exp, input int dly);
    vec_t v;
    v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
    v.off = off; v.exp = exp; v.dly = dly;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fire();
    sw_trig = 1'b1;
    @(negedge clk);
    sw_trig = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!ts_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  vec_t vecs[6];
  vec_t v;
  bit   ok;
  int   b_start, b_bad, b_valid, b_err, b_en;

  initial begin
    vecs[0] = mk(8'd10,  8'd11,  8'd12,  8'd13,  4'hE, 8'd9,   425);
    vecs[1] = mk(8'd255, 8'd255, 8'd255, 8'd255, 4'h7, 8'd255, 30);
    vecs[2] = mk(8'd0,   8'd0,   8'd0,   8'd0,   4'h8, 8'd0,   30);
    vecs[3] = mk(8'd100, 8'd101, 8'd102, 8'd103, 4'h0, 8'd101, 30);
    vecs[4] = mk(8'd1,   8'd2,   8'd3,   8'd4,   4'h9, 8'd0,   30);
    vecs[5] = mk(8'd200, 8'd201, 8'd202, 8'd203, 4'h5, 8'd206, 30);

    RSTn = 1'b0; FLOCK = 1'b1; reg_ts_en_sel = 1'b0; sw_trig = 1'b0; reg_offset = 4'h0;
    tick(4);
    check("rst_en",    D2A_TS_EN, 0);
    check("rst_start", D2A_TS_START_EN, 0);
    check("rst_out",   ts_out, 0);
    check("rst_valid", ts_valid, 0);
    check("rst_err",   ts_err, 0);
    check("rst_busy",  ts_busy, 0);
    RSTn = 1'b1;
    tick(3);

    // Single-shot rounds from the vector table.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      for (int k = 0; k < 4; k++) samp_q.push_back(v.s[k]);
      conv_dly = v.dly; reg_offset = v.off;
      b_start = start_pulses; b_bad = bad_width; b_valid = valid_cnt; b_err = err_cnt;
      fire();
      wait_idle(8000, ok);
      tick(2);
      check($sformatf("v%0d_done", i),   ok, 1);
      check($sformatf("v%0d_ts_out", i), ts_out, v.exp);
      check($sformatf("v%0d_starts", i), start_pulses - b_start, 4);
      check($sformatf("v%0d_width", i),  bad_width - b_bad, 0);
      check($sformatf("v%0d_valid", i),  valid_cnt - b_valid, 1);
      check($sformatf("v%0d_err", i),    err_cnt - b_err, 0);
      check($sformatf("v%0d_en_low", i), D2A_TS_EN, 0);
    end

    // DETOK left high from the last conversion: never armed, must time out.
    sens_mode = SENS_STUCK1; sens_starts = 0;
    b_start = start_pulses; b_valid = valid_cnt; b_err = err_cnt;
    fire();
    wait_idle(3000, ok);
    tick(2);
    check("stuck1_done",   ok, 1);
    check("stuck1_err",    err_cnt - b_err, 1);
    check("stuck1_valid",  valid_cnt - b_valid, 0);
    check("stuck1_starts", start_pulses - b_start, 1);
    check("stuck1_tmo",    err_t - wait_entry_t, TIMEOUT_CYC);
    check("stuck1_out",    ts_out, 206);
    check("stuck1_en_low", D2A_TS_EN, 0);

    // DETOK stuck low after the second START.
    sens_mode = SENS_STUCK0; sens_starts = 0; stuck_after = 2; conv_dly = 30;
    samp_q.push_back(8'd50); samp_q.push_back(8'd60);
    b_start = start_pulses; b_valid = valid_cnt; b_err = err_cnt;
    fire();
    wait_idle(3000, ok);
    tick(2);
    check("stuck0_done",   ok, 1);
    check("stuck0_err",    err_cnt - b_err, 1);
    check("stuck0_valid",  valid_cnt - b_valid, 0);
    check("stuck0_starts", start_pulses - b_start, 3);
    check("stuck0_tmo",    err_t - wait_entry_t, TIMEOUT_CYC);
    check("stuck0_out",    ts_out, 206);
    check("stuck0_en_low", D2A_TS_EN, 0);

    // FLOCK lost in the third WAIT_OK; the next round must use only fresh samples.
    sens_mode = SENS_NORMAL; conv_dly = 100; reg_offset = 4'h0;
    samp_q.push_back(8'd200); samp_q.push_back(8'd200); samp_q.push_back(8'd200);
    samp_q.push_back(8'd20);  samp_q.push_back(8'd20);
    samp_q.push_back(8'd24);  samp_q.push_back(8'd24);
    b_start = start_pulses; b_valid = valid_cnt; b_err = err_cnt;
    fire();
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (start_pulses >= b_start + 3) begin
        ok = 1'b1;
        break;
      end
    end
    check("flock_reach_wait3", ok, 1);
    tick(20);
    FLOCK = 1'b0;
    @(negedge clk);
    check("flock_en_low",    D2A_TS_EN, 0);
    check("flock_start_low", D2A_TS_START_EN, 0);
    check("flock_busy_low",  ts_busy, 0);
    tick(120);
    FLOCK = 1'b1;
    tick(2);
    check("flock_no_valid", valid_cnt - b_valid, 0);
    check("flock_no_err",   err_cnt - b_err, 0);
    b_start = start_pulses; b_valid = valid_cnt;
    fire();
    wait_idle(3000, ok);
    tick(2);
    check("fresh_done",   ok, 1);
    check("fresh_ts_out", ts_out, 22);
    check("fresh_valid",  valid_cnt - b_valid, 1);
    check("fresh_starts", start_pulses - b_start, 4);

    // Continuous mode: three rounds, EN rising edges one period apart.
    conv_dly = 30; reg_offset = 4'h0;
    for (int k = 0; k < 12; k++) samp_q.push_back(8'd40);
    b_en = en_rises; b_valid = valid_cnt;
    reg_ts_en_sel = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 14000; i++) begin
      @(negedge clk);
      if (en_rises >= b_en + 3) begin
        ok = 1'b1;
        break;
      end
    end
    reg_ts_en_sel = 1'b0;
    check("cont_three_rounds", ok, 1);
    wait_idle(3000, ok);
    tick(2);
    check("cont_done", ok, 1);
    if (en_rise_t.size() >= b_en + 3) begin
      check("cont_period_1", en_rise_t[b_en + 1] - en_rise_t[b_en], PERIOD_CYC);
      check("cont_period_2", en_rise_t[b_en + 2] - en_rise_t[b_en + 1], PERIOD_CYC);
    end else begin
      check("cont_rise_count", en_rises - b_en, 3);
    end
    check("cont_valid",  valid_cnt - b_valid, 3);
    check("cont_ts_out", ts_out, 40);

    // Asynchronous reset in the middle of a START pulse.
    for (int k = 0; k < 4; k++) samp_q.push_back(8'd5);
    fire();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (D2A_TS_START_EN) begin
        ok = 1'b1;
        break;
      end
    end
    check("arst_saw_start", ok, 1);
    #2 RSTn = 1'b0;
    #1;
    check("arst_en",    D2A_TS_EN, 0);
    check("arst_start", D2A_TS_START_EN, 0);
    check("arst_busy",  ts_busy, 0);
    check("arst_out",   ts_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
